// File: rtl/mem_arb_pkg.sv
// Shared constants for the record-RAM arbiter: requester indices, default widths
// and the arbiter state encoding.
package mem_arb_pkg;

  localparam int N_REQ_DEF    = 3;
  localparam int ADDR_W_DEF   = 10;
  localparam int DATA_W_DEF   = 8;
  localparam int LOCK_MAX_DEF = 64;

  localparam int REQ_SCS  = 0;
  localparam int REQ_SET  = 1;
  localparam int REQ_SEND = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             any_o
);

  int j;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    any_o     = 1'b0;
    j         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (!any_o && req_i[j]) begin
        any_o       = 1'b1;
        win_oh_o[j] = 1'b1;
        win_idx_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter in front of the single-port record RAM, with locked bursts
// and read-data steering. Optional lock watchdog: define MEM_ARB_WATCHDOG_EN.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0]        i_lock,
  input  logic [N_REQ-1:0]        i_we,
  input  logic [N_REQ*ADDR_W-1:0] i_addr,
  input  logic [N_REQ*DATA_W-1:0] i_wdata,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [N_REQ-1:0]        o_rvalid,
  output logic [DATA_W-1:0]       o_rdata,
  output logic                    o_mem_en,
  output logic                    o_mem_we,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic [DATA_W-1:0]       o_mem_wdata,
  input  logic [DATA_W-1:0]       i_mem_rdata,
  output logic                    o_lock_timeout
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [N_REQ-1:0][DATA_W-1:0] wdata_v;

  arb_state_e       state_q;
  logic [IDX_W-1:0] owner_q, ptr_q;
  logic [N_REQ-1:0] gnt_q, rvalid_q;

  logic [IDX_W-1:0] owner_inc, pick_ptr, pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic             pick_any, keep_lock, hold, wd_expire;

  assign addr_v  = i_addr;
  assign wdata_v = i_wdata;

  assign owner_inc = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  // Releasing an owner re-arbitrates in the same edge from owner+1, so the
  // pointer fed to the picker is the post-release value, not the stale one.
  assign pick_ptr  = (state_q == ST_OWN) ? owner_inc : ptr_q;
  assign keep_lock = (state_q == ST_OWN) && i_lock[owner_q] && i_req[owner_q];
  assign hold      = keep_lock && !wd_expire;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i     (i_req),
    .ptr_i     (pick_ptr),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= (o_mem_en && !o_mem_we) ? gnt_q : '0;
      if (!hold) begin
        if (state_q == ST_OWN) ptr_q <= owner_inc;
        if (pick_any) begin
          state_q <= ST_OWN;
          owner_q <= pick_idx;
          gnt_q   <= pick_oh;
        end else begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      end
    end
  end

`ifdef MEM_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [CNT_W-1:0] lock_cnt_q;
  logic             timeout_q;

  // The counter holds the number of back-to-back grants already given to the owner.
  assign wd_expire = keep_lock && (lock_cnt_q >= CNT_W'(LOCK_MAX));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (hold)          lock_cnt_q <= lock_cnt_q + CNT_W'(1);
      else if (pick_any) lock_cnt_q <= CNT_W'(1);
      else               lock_cnt_q <= '0;
      if (wd_expire) timeout_q <= 1'b1;
    end
  end

  assign o_lock_timeout = timeout_q;
`else
  assign wd_expire      = 1'b0;
  assign o_lock_timeout = 1'b0;
`endif

  assign o_gnt       = gnt_q;
  assign o_rvalid    = rvalid_q;
  assign o_rdata     = i_mem_rdata;
  assign o_mem_en    = |gnt_q;
  assign o_mem_we    = o_mem_en & i_we[owner_q];
  assign o_mem_addr  = o_mem_en ? addr_v[owner_q]  : '0;
  assign o_mem_wdata = o_mem_en ? wdata_v[owner_q] : '0;

  a_gnt_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(gnt_q));
  a_rv_onehot:  assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(rvalid_q));

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: directed stimulus pushes expected grants and
// read returns, a free-running monitor pops and compares them cycle by cycle.
module tb_mem_arb;

  logic                 i_clk = 1'b0;
  logic                 rst_n;
  logic [2:0]           req, lock, we;
  logic [2:0][9:0]      addr_v;
  logic [2:0][7:0]      wdata_v;
  logic [7:0]           mrd;
  logic [2:0]           o_gnt, o_rvalid;
  logic [7:0]           o_rdata, o_mem_wdata;
  logic                 o_mem_en, o_mem_we, o_lock_timeout;
  logic [9:0]           o_mem_addr;

  always #5 i_clk = ~i_clk;

  mem_arb #(.N_REQ(3), .ADDR_W(10), .DATA_W(8), .LOCK_MAX(4)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (rst_n),
    .i_req          (req),
    .i_lock         (lock),
    .i_we           (we),
    .i_addr         (addr_v),
    .i_wdata        (wdata_v),
    .o_gnt          (o_gnt),
    .o_rvalid       (o_rvalid),
    .o_rdata        (o_rdata),
    .o_mem_en       (o_mem_en),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .i_mem_rdata    (mrd),
    .o_lock_timeout (o_lock_timeout)
  );

  typedef struct {
    int         cyc;
    logic [2:0] gnt;
    logic [9:0] addr;
    logic       we;
    logic [7:0] wd;
  } gexp_t;

  typedef struct {
    int         cyc;
    logic [2:0] rv;
    logic [7:0] rd;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic pg(input int c, input logic [2:0] g, input logic [9:0] a,
                    input logic w, input logic [7:0] d);
    gexp_t e;
    e.cyc = c; e.gnt = g; e.addr = a; e.we = w; e.wd = d;
    gq.push_back(e);
  endtask

  task automatic pr(input int c, input logic [2:0] r, input logic [7:0] d);
    rexp_t e;
    e.cyc = c; e.rv = r; e.rd = d;
    rq.push_back(e);
  endtask

  // Monitor: samples 1ns after each rising edge, inputs change only on falling edges.
  always begin
    gexp_t ge;
    rexp_t re;
    @(posedge i_clk);
    #1;
    if (o_gnt != 3'b000) begin
      if (gq.size() == 0) chk("gnt_unexpected", 32'(o_gnt), 32'h0);
      else begin
        ge = gq.pop_front();
        chk("gnt_cycle", cyc, ge.cyc);
        chk("gnt", 32'(o_gnt), 32'(ge.gnt));
        chk("mem_en", 32'(o_mem_en), 32'h1);
        chk("mem_we", 32'(o_mem_we), 32'(ge.we));
        chk("mem_addr", 32'(o_mem_addr), 32'(ge.addr));
        chk("mem_wdata", 32'(o_mem_wdata), 32'(ge.wd));
      end
    end else if (gq.size() != 0 && gq[0].cyc <= cyc) begin
      ge = gq.pop_front();
      chk("gnt_missing", 32'(o_gnt), 32'(ge.gnt));
    end else begin
      chk("idle_mem_en", 32'(o_mem_en), 32'h0);
      chk("idle_mem_addr", 32'(o_mem_addr), 32'h0);
    end
    if (o_rvalid != 3'b000) begin
      if (rq.size() == 0) chk("rvalid_unexpected", 32'(o_rvalid), 32'h0);
      else begin
        re = rq.pop_front();
        chk("rvalid_cycle", cyc, re.cyc);
        chk("rvalid", 32'(o_rvalid), 32'(re.rv));
        chk("rdata", 32'(o_rdata), 32'(re.rd));
      end
    end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
      re = rq.pop_front();
      chk("rvalid_missing", 32'(o_rvalid), 32'(re.rv));
    end
  end

  task automatic clr();
    req = '0; lock = '0; we = '0; addr_v = '0; wdata_v = '0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    rst_n = 1'b0;
    clr();
    repeat (2) @(negedge i_clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_gnt"}, 32'(o_gnt), 32'h0);
    chk({nm, "_rvalid"}, 32'(o_rvalid), 32'h0);
    chk({nm, "_mem_en"}, 32'(o_mem_en), 32'h0);
    chk({nm, "_mem_we"}, 32'(o_mem_we), 32'h0);
    chk({nm, "_mem_addr"}, 32'(o_mem_addr), 32'h0);
    chk({nm, "_mem_wdata"}, 32'(o_mem_wdata), 32'h0);
    chk({nm, "_timeout"}, 32'(o_lock_timeout), 32'h0);
  endtask

  int t, r;

  initial begin
    rst_n = 1'b0;
    clr();
    mrd = 8'h00;
    repeat (2) @(negedge i_clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Single read from requester 1
    t = cyc;
    req = 3'b010; addr_v[1] = 10'h005; mrd = 8'hA5;
    pg(t + 1, 3'b010, 10'h005, 1'b0, 8'h00);
    pr(t + 2, 3'b010, 8'hA5);
    @(negedge i_clk); req = 3'b000;
    repeat (3) @(negedge i_clk);

    // All three requesting unlocked: strict rotation, no gaps
    do_reset();
    t = cyc;
    req = 3'b111; we = 3'b001; mrd = 8'h3C;
    addr_v[0] = 10'h100; wdata_v[0] = 8'h11;
    addr_v[1] = 10'h101; addr_v[2] = 10'h102;
    for (int k = 0; k < 2; k++) begin
      pg(t + 1 + 3*k, 3'b001, 10'h100, 1'b1, 8'h11);
      pg(t + 2 + 3*k, 3'b010, 10'h101, 1'b0, 8'h00);
      pg(t + 3 + 3*k, 3'b100, 10'h102, 1'b0, 8'h00);
      pr(t + 3 + 3*k, 3'b010, 8'h3C);
      pr(t + 4 + 3*k, 3'b100, 8'h3C);
    end
    repeat (6) @(negedge i_clk);
    req = 3'b000;
    repeat (3) @(negedge i_clk);

    // Locked 4-beat write burst from requester 2 while 0 and 1 wait
    do_reset();
    t = cyc;
    req = 3'b100; lock = 3'b100; we = 3'b100; mrd = 8'h5A;
    addr_v[2] = 10'h010; wdata_v[2] = 8'hD0;
    for (int b = 0; b < 4; b++) pg(t + 1 + b, 3'b100, 10'(10'h010 + b), 1'b1, 8'(8'hD0 + b));
    pg(t + 5, 3'b001, 10'h020, 1'b0, 8'h00);
    pg(t + 6, 3'b010, 10'h021, 1'b0, 8'h00);
    pr(t + 6, 3'b001, 8'h5A);
    pr(t + 7, 3'b010, 8'h5A);
    @(negedge i_clk);
    addr_v[2] = 10'h011; wdata_v[2] = 8'hD1;
    req = 3'b111; addr_v[0] = 10'h020; addr_v[1] = 10'h021;
    for (int b = 2; b < 4; b++) begin
      @(negedge i_clk);
      addr_v[2] = 10'(10'h010 + b); wdata_v[2] = 8'(8'hD0 + b);
    end
    @(negedge i_clk); req[2] = 1'b0; lock = 3'b000;
    @(negedge i_clk); req[0] = 1'b0;
    @(negedge i_clk); req[1] = 1'b0;
    repeat (3) @(negedge i_clk);

    // Reset in the middle of a locked read burst
    do_reset();
    t = cyc;
    req = 3'b100; lock = 3'b100; addr_v[2] = 10'h030; mrd = 8'hC3;
    pg(t + 1, 3'b100, 10'h030, 1'b0, 8'h00);
    pg(t + 2, 3'b100, 10'h030, 1'b0, 8'h00);
    pr(t + 2, 3'b100, 8'hC3);
    repeat (2) @(negedge i_clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midburst_reset");
    clr();
    req = 3'b011; addr_v[0] = 10'h031; addr_v[1] = 10'h032;
    repeat (2) @(negedge i_clk);
    rst_n = 1'b1;
    r = cyc;
    pg(r + 1, 3'b001, 10'h031, 1'b0, 8'h00);
    pg(r + 2, 3'b010, 10'h032, 1'b0, 8'h00);
    pr(r + 2, 3'b001, 8'hC3);
    pr(r + 3, 3'b010, 8'hC3);
    @(negedge i_clk); req[0] = 1'b0;
    @(negedge i_clk); req[1] = 1'b0;
    repeat (3) @(negedge i_clk);

    // Requester 0 holds its lock indefinitely while 1 waits
    do_reset();
    t = cyc;
    req = 3'b011; lock = 3'b001; mrd = 8'h96;
    addr_v[0] = 10'h040; addr_v[1] = 10'h041;
`ifdef MEM_ARB_WATCHDOG_EN
    for (int b = 0; b < 4; b++) pg(t + 1 + b, 3'b001, 10'h040, 1'b0, 8'h00);
    pg(t + 5, 3'b010, 10'h041, 1'b0, 8'h00);
    for (int b = 0; b < 4; b++) pr(t + 2 + b, 3'b001, 8'h96);
    pr(t + 6, 3'b010, 8'h96);
    repeat (4) @(negedge i_clk);
    chk("timeout_before", 32'(o_lock_timeout), 32'h0);
    @(negedge i_clk);
    chk("timeout_set", 32'(o_lock_timeout), 32'h1);
    clr();
    repeat (4) @(negedge i_clk);
    chk("timeout_sticky", 32'(o_lock_timeout), 32'h1);
`else
    for (int b = 0; b < 6; b++) pg(t + 1 + b, 3'b001, 10'h040, 1'b0, 8'h00);
    pg(t + 7, 3'b010, 10'h041, 1'b0, 8'h00);
    for (int b = 0; b < 6; b++) pr(t + 2 + b, 3'b001, 8'h96);
    pr(t + 8, 3'b010, 8'h96);
    repeat (6) @(negedge i_clk);
    chk("timeout_off", 32'(o_lock_timeout), 32'h0);
    req = 3'b010; lock = 3'b000;
    @(negedge i_clk); req = 3'b000;
    repeat (3) @(negedge i_clk);
    chk("timeout_off_end", 32'(o_lock_timeout), 32'h0);
`endif

    // Write then read of the same address by different requesters; a lock
    // without a request must not hold a grant
    do_reset();
    t = cyc;
    req = 3'b011; we = 3'b001; mrd = 8'h77;
    addr_v[0] = 10'h055; wdata_v[0] = 8'h77; addr_v[1] = 10'h055;
    pg(t + 1, 3'b001, 10'h055, 1'b1, 8'h77);
    pg(t + 2, 3'b010, 10'h055, 1'b0, 8'h00);
    pr(t + 3, 3'b010, 8'h77);
    @(negedge i_clk); req[0] = 1'b0;
    @(negedge i_clk); req[1] = 1'b0; lock = 3'b010;
    repeat (4) @(negedge i_clk);
    clr();
    repeat (2) @(negedge i_clk);

    chk("gnt_queue_drained", 32'(gq.size()), 32'h0);
    chk("rvalid_queue_drained", 32'(rq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
